// File: rtl/spi_master_param.sv
// spi_master_param: parametrised full-duplex SPI master with a valid/ready
// request port, runtime CPOL/CPHA per transfer and NUM_CS chip selects.
// Frame: IDLE -> SETUP (CLK_DIV) -> XFER (2*DATA_W half-periods) -> HOLD
// (CLK_DIV) -> IDLE. rx_valid pulses in the first IDLE cycle after HOLD.
// Optional: define SPI_LSB_FIRST_EN to add the lsb_first port, which selects
// LSB-first shifting for both mosi and rx_data.
module spi_master_param #(
    parameter  int DATA_W  = 8,
    parameter  int CLK_DIV = 4,
    parameter  int NUM_CS  = 1,
    localparam int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
`ifdef SPI_LSB_FIRST_EN
    ,
    input  logic              lsb_first
`endif
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HP_W  = $clog2(2 * DATA_W) + 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  div_cnt;
    logic [HP_W-1:0]   half_cnt;
    logic              cpol_r, cpha_r, lsb_r, lsb_in;
    logic [CS_W-1:0]   cs_r;
    logic [DATA_W-1:0] tx_sh, rx_sh;
    logic              accept, div_end, lead_edge, trail_edge, last_edge;
    logic              shift_edge, sample_edge, done;

    // Bit that goes on the wire next, given the current bit order.
    function automatic logic head_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    // Drop the bit just placed on the wire.
    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
    endfunction

    // Insert a received bit so the first bit on the wire ends at the MSB (or LSB).
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b,
                                                   input logic lsb);
        return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
    endfunction

    assign tx_ready    = (state == IDLE) && !rst;
    assign accept      = tx_valid && tx_ready;
    assign div_end     = (div_cnt == DIV_LAST);
    // Even half-periods end with the leading SCLK edge, odd ones with the trailing edge.
    assign lead_edge   = (state == XFER) && div_end && !half_cnt[0];
    assign trail_edge  = (state == XFER) && div_end && half_cnt[0];
    assign last_edge   = trail_edge && (half_cnt == HP_LAST);
    assign shift_edge  = cpha_r ? lead_edge : (trail_edge && !last_edge);
    assign sample_edge = cpha_r ? trail_edge : lead_edge;
    assign done        = (state == HOLD) && div_end;
    assign busy        = (state != IDLE) || rx_valid;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_in = lsb_first;
    // Bit order of the frame in flight, captured at accept.
    always_ff @(posedge clk) begin
        if (rst)         lsb_r <= 1'b0;
        else if (accept) lsb_r <= lsb_first;
    end
`else
    assign lsb_in = 1'b0;
    assign lsb_r  = 1'b0;
`endif

    // Next-state and chip-select decode.
    always_comb begin
        state_nx = state;
        cs_n     = '1;
        case (state)
            IDLE:    if (accept) state_nx = SETUP;
            SETUP:   if (div_end) state_nx = XFER;
            XFER:    if (last_edge) state_nx = HOLD;
            HOLD:    if (done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // An out-of-range cs_sel matches no line, so the frame runs with all selects high.
        if (state != IDLE) begin
            for (int i = 0; i < NUM_CS; i++) begin
                if (cs_r == CS_W'(i)) cs_n[i] = 1'b0;
            end
        end
    end

    // Control state, timing counters and registered SPI pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            half_cnt <= '0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            cpol_r   <= 1'b0;
            cpha_r   <= 1'b0;
            cs_r     <= '0;
        end else begin
            state    <= state_nx;
            rx_valid <= done;
            div_cnt  <= ((state == IDLE) || div_end) ? '0 : div_cnt + CNT_W'(1);
            if (state != XFER)  half_cnt <= '0;
            else if (div_end)   half_cnt <= half_cnt + HP_W'(1);
            if (accept) begin
                cpol_r <= cpol;
                cpha_r <= cpha;
                cs_r   <= cs_sel;
                sclk   <= cpol;
                // With cpha=1 the first bit goes out on the first leading edge.
                mosi   <= cpha ? 1'b0 : head_bit(tx_data, lsb_in);
            end else begin
                if ((state == XFER) && div_end) sclk <= ~sclk;
                if (shift_edge)  mosi <= head_bit(tx_sh, lsb_r);
                else if (done)   mosi <= 1'b0;
            end
            if (done) rx_data <= rx_sh;
        end
    end

    // Transmit and receive shift registers.
    always_ff @(posedge clk) begin
        if (accept)          tx_sh <= cpha ? tx_data : shift_out(tx_data, lsb_in);
        else if (shift_edge) tx_sh <= shift_out(tx_sh, lsb_r);
        if (sample_edge)     rx_sh <= shift_in(rx_sh, miso, lsb_r);
    end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
Parametrised, full-duplex SPI master with a valid/ready transmit interface, receive capture on MISO, runtime-selectable SPI mode (CPOL/CPHA) and multiple chip selects. It replaces the fixed 8-bit, mode-0, transmit-only master. Configurable word width and SCLK divider. Sits between a local controller and off-chip SPI slaves.

Parameters:
DATA_W, 8, bits per transfer (>= 2)
CLK_DIV, 4, clk cycles per SCLK half-period (>= 1); SCLK = clk/(2*CLK_DIV)
NUM_CS, 1, number of chip-select lines (>= 1); CS_W = (NUM_CS>1) ? $clog2(NUM_CS) : 1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
tx_valid  input  1  transfer request
tx_ready  output  1  block idle and able to accept
tx_data  input  DATA_W  word to shift out
cs_sel  input  CS_W  slave index for this transfer
cpol  input  1  SCLK idle level for this transfer
cpha  input  1  0: sample on leading edge; 1: sample on trailing edge
rx_valid  output  1  one-cycle pulse, rx_data valid
rx_data  output  DATA_W  word captured from MISO
busy  output  1  high from accept until rx_valid cycle inclusive
sclk  output  1  SPI clock
mosi  output  1  serial data out
miso  input  1  serial data in
cs_n  output  NUM_CS  active-low chip selects

Behaviour:
- Reset values: sclk=0, mosi=0, cs_n=all 1, rx_valid=0, rx_data=0, busy=0, tx_ready=0 while rst high; state=IDLE.
- Reset mid-transfer: all outputs to reset values on the next edge, no rx_valid, word dropped.
- States: IDLE -> SETUP -> XFER -> HOLD -> IDLE.
- IDLE: tx_ready=1. Accept on tx_valid && tx_ready: latch tx_data, cs_sel, cpol, cpha. Mode and data inputs are ignored at all other times. sclk rests at the last latched cpol (0 after reset).
- SETUP: CLK_DIV cycles. cs_n[cs_sel]=0; sclk=cpol. cpha=0: mosi=first bit. cpha=1: mosi=0.
- XFER: 2*DATA_W half-periods of CLK_DIV cycles. sclk toggles at the end of each half-period, giving exactly DATA_W leading and DATA_W trailing edges.
  - cpha=0: miso is sampled into the shift register on each leading edge; mosi advances on each trailing edge except the last.
  - cpha=1: mosi advances on each leading edge, with the first leading edge driving the first bit; miso is sampled on each trailing edge.
- Bit order is MSB first. rx_data is assembled MSB first.
- HOLD: CLK_DIV cycles. sclk=cpol; cs_n is held low; mosi holds the last bit.
- Completion: the cycle after HOLD, cs_n returns to all 1, mosi=0, rx_valid=1 for one cycle with rx_data, and tx_ready=1 in the same cycle. rx_data holds until the next completion.
- Timing: cs_n is low for exactly (2*DATA_W+2)*CLK_DIV cycles, starting the cycle after accept.
- Back-to-back: accepting in the rx_valid cycle gives cs_n high for exactly 1 cycle between frames.
- tx_valid while busy is not captured.
- cs_sel >= NUM_CS: no cs_n asserted. The transfer otherwise runs normally and rx_valid still pulses.
- CLK_DIV=1: sclk toggles every clk cycle; the same edge rules apply.

Optional Feature:
SPI_LSB_FIRST_EN
- Defined: adds input port lsb_first (1 bit), latched at accept. When 1, both mosi and rx_data are LSB first; when 0, MSB first.
- Undefined: port absent, MSB first always, no extra logic.

Test Plan:
- DATA_W=8, CLK_DIV=4, mode 0, tx_data=0xEB, miso looped to mosi -> mosi 1,1,1,0,1,0,1,1 sampled on 8 rising edges; cs_n low 72 cycles; rx_valid with rx_data=0xEB.
- Mode 3 (cpol=1, cpha=1), tx_data=0x3C, slave model drives 0xA5 -> sclk idles high; mosi changes on falling edges; rx_data=0xA5 sampled on rising edges.
- Two queued words 0x12, 0x34, tx_valid held -> second accepted in the rx_valid cycle; cs_n high exactly 1 cycle between frames; rx_data 0x12 then 0x34.
- NUM_CS=4, cs_sel=2 -> only cs_n[2] toggles. cs_sel=3 with NUM_CS=3 -> no cs_n low, rx_valid still pulses.
- rst asserted at half-period 5 of XFER -> next cycle: cs_n all 1, sclk=0, mosi=0, tx_ready=0 while rst high, no rx_valid.
- SPI_LSB_FIRST_EN, lsb_first=1, tx_data=0x01, loopback -> mosi 1,0,0,0,0,0,0,0; rx_data=0x01.
